// File: rtl/mux2x1_arbiter.sv
// rtl/mux2x1_arbiter.sv - round-robin arbiter driving a registered 2:1 data mux
module mux2x1_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last;

  logic             own_side;
  logic             own_req;
  logic             oth_req;
  logic [WIDTH-1:0] own_din;
  logic [CW-1:0]    cnt_inc;
  logic             burst_done;

  // Fold the two grant states onto "owner" and "other" so both sides share one path
  always_comb begin
    own_side   = 1'b0;
    own_req    = req0;
    oth_req    = req1;
    own_din    = din0;
    if (state == GRANT1) begin
      own_side = 1'b1;
      own_req  = req1;
      oth_req  = req0;
      own_din  = din1;
    end
    cnt_inc    = cnt + 1'b1;
    burst_done = own_req && (cnt_inc == CW'(MAX_BURST));
  end

  // Arbitration state, beat counting and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      sel      <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      last     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          dout_vld <= 1'b0;
          cnt      <= '0;
          // On a tie the side that was not served last wins
          if (req0 && (!req1 || last)) begin
            state <= GRANT0;
            gnt0  <= 1'b1;
            gnt1  <= 1'b0;
            sel   <= 1'b0;
            busy  <= 1'b1;
          end else if (req1) begin
            state <= GRANT1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b1;
            sel   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (own_req) begin
            dout     <= own_din;
            dout_vld <= 1'b1;
            cnt      <= cnt_inc;
          end else begin
            dout_vld <= 1'b0;
          end
          // Release on a dropped request or on the burst-limit beat
          if (!own_req || burst_done) begin
            last <= own_side;
            cnt  <= '0;
            if (oth_req) begin
              state <= own_side ? GRANT0 : GRANT1;
              gnt0  <= own_side;
              gnt1  <= !own_side;
              sel   <= !own_side;
              busy  <= 1'b1;
            end else if (own_req) begin
              state <= own_side ? GRANT1 : GRANT0;
              gnt0  <= !own_side;
              gnt1  <= own_side;
              sel   <= own_side;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
              gnt0  <= 1'b0;
              gnt1  <= 1'b0;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// tb/tb_mux2x1_arbiter.sv - randomized and directed check of mux2x1_arbiter against an ownership model
module tb_mux2x1_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] din0, din1;

  logic       g0_a, g1_a, sel_a, vld_a, busy_a;
  logic [7:0] dout_a;
  logic       g0_b, g1_b, sel_b, vld_b, busy_b;
  logic [7:0] dout_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mux2x1_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_mb4 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(g0_a), .gnt1(g1_a), .sel(sel_a), .dout(dout_a), .dout_vld(vld_a), .busy(busy_a)
  );

  mux2x1_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_mb1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(g0_b), .gnt1(g1_b), .sel(sel_b), .dout(dout_b), .dout_vld(vld_b), .busy(busy_b)
  );

  // Model: who owns the channel (-1 none), beats in the current grant, who was served last
  int         m_burst [2] = '{4, 1};
  int         m_owner [2];
  int         m_beats [2];
  int         m_last  [2];
  int         m_sel   [2];
  logic [7:0] m_dout  [2];
  logic       m_vld   [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1; m_beats[i] = 0; m_last[i] = 1;
      m_sel[i] = 0; m_dout[i] = 8'h00; m_vld[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit r0, input bit r1, input logic [7:0] d0, input logic [7:0] d1);
    bit r [2];
    logic [7:0] d [2];
    r[0] = r0; r[1] = r1; d[0] = d0; d[1] = d1;
    for (int i = 0; i < 2; i++) begin
      if (m_owner[i] < 0) begin
        m_vld[i] = 1'b0;
        if (r0 && r1)  m_owner[i] = 1 - m_last[i];
        else if (r0)   m_owner[i] = 0;
        else if (r1)   m_owner[i] = 1;
      end else begin
        int x;
        x = m_owner[i];
        m_vld[i] = r[x];
        if (r[x]) begin
          m_dout[i] = d[x];
          m_beats[i]++;
        end
        if (!r[x] || m_beats[i] == m_burst[i]) begin
          m_last[i]  = x;
          m_beats[i] = 0;
          if (r[1-x])    m_owner[i] = 1 - x;
          else if (r[x]) m_owner[i] = x;
          else           m_owner[i] = -1;
        end
      end
      if (m_owner[i] >= 0) m_sel[i] = m_owner[i];
    end
  endfunction

  function automatic logic [12:0] model_vec(input int i);
    return {m_owner[i] == 0, m_owner[i] == 1, m_sel[i] != 0, m_owner[i] >= 0, m_vld[i], m_dout[i]};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (g0,g1,sel,busy,vld,dout)", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/mb4"}, {g0_a, g1_a, sel_a, busy_a, vld_a, dout_a}, model_vec(0));
    check({tag, "/mb1"}, {g0_b, g1_b, sel_b, busy_b, vld_b, dout_b}, model_vec(1));
  endtask

  // One clock: drive, take the edge, update the model, sample 1 time unit later
  task automatic step(input string tag, input bit r0, input bit r1, input logic [7:0] d0, input logic [7:0] d1);
    req0 = r0; req1 = r1; din0 = d0; din1 = d1;
    @(posedge clk);
    model_edge(r0, r1, d0, d1);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = 8'h00; din1 = 8'h00;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all("reset");
    rst = 1'b0;

    // Tie from IDLE right after reset: requester 0 wins
    step("tie_first", 1, 1, 8'hA0, 8'hB0);
    step("tie_first", 0, 0, 8'hA1, 8'hB1);
    step("tie_first", 0, 0, 8'hA2, 8'hB2);

    // Lone requester 0 across a burst boundary
    for (int k = 0; k < 6; k++) step("single", 1, 0, 8'h11 + 8'(k), 8'hEE);
    step("single", 0, 0, 8'h00, 8'h00);
    step("single", 0, 0, 8'h00, 8'h00);

    // Continuous contention
    for (int k = 0; k < 14; k++) step("contend", 1, 1, 8'h20 + 8'(k), 8'h40 + 8'(k));

    // Idle return, sel holds, then lone req1
    for (int k = 0; k < 3; k++) step("idle", 0, 0, 8'h00, 8'h00);
    step("lone_req1", 0, 1, 8'h00, 8'h51);
    step("lone_req1", 0, 1, 8'h00, 8'h52);
    step("lone_req1", 0, 0, 8'h00, 8'h53);
    step("lone_req1", 0, 0, 8'h00, 8'h54);

    // Early drop by requester 0 after two beats while req1 waits
    step("early_drop", 1, 0, 8'h61, 8'h00);
    step("early_drop", 1, 1, 8'h62, 8'h71);
    step("early_drop", 1, 1, 8'h63, 8'h72);
    for (int k = 0; k < 6; k++) step("early_drop", 0, 1, 8'h00, 8'h73 + 8'(k));
    step("early_drop", 0, 0, 8'h00, 8'h00);
    step("early_drop", 0, 0, 8'h00, 8'h00);

    // Asynchronous reset in GRANT1 with two beats done
    step("pre_rst", 0, 1, 8'h00, 8'h81);
    step("pre_rst", 0, 1, 8'h00, 8'h82);
    step("pre_rst", 0, 1, 8'h00, 8'h83);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    step("post_rst_tie", 1, 1, 8'h91, 8'h92);
    step("post_rst_tie", 1, 1, 8'h93, 8'h94);

    // Randomized traffic with sticky requests so bursts form
    for (int k = 0; k < 400; k++) begin
      bit r0, r1;
      r0 = ($urandom_range(0, 9) < 7);
      r1 = ($urandom_range(0, 9) < 6);
      step("random", r0, r1, 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux2x1_arbiter.md
# mux2x1_arbiter

Round-robin controller that shares one registered 2:1 data mux between two requesters. It owns the select line, issues one-hot grants, and caps each ownership period at MAX_BURST beats so neither side can starve the other. It sits in front of the mux2x1 datapath. It converts the combinational select into a clocked, fair, handshaked channel feeding a single downstream consumer.

## Interface
- WIDTH, 8: data width of each input and of dout.
- MAX_BURST, 4: maximum beats per grant; legal range ≥ 1.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 wants the channel; a beat is transferred while high and granted.
- req1  input  1  requester 1, same meaning.
- din0  input  WIDTH  requester 0 data, sampled on a beat.
- din1  input  WIDTH  requester 1 data, sampled on a beat.
- gnt0  output  1  requester 0 owns the channel (registered).
- gnt1  output  1  requester 1 owns the channel (registered).
- sel  output  1  mux select: 0 = input 0, 1 = input 1 (registered).
- dout  output  WIDTH  registered mux output.
- dout_vld  output  1  dout holds a beat this cycle.
- busy  output  1  high whenever a grant is active.

## Operation
- States: IDLE, GRANT0, GRANT1. Internal regs: beat counter cnt (width $clog2(MAX_BURST+1)) and last-served flag last.
- Reset values: IDLE, gnt0=gnt1=0, sel=0, dout=0, dout_vld=0, busy=0, cnt=0, last=1. With last=1, requester 0 wins the first tie.
- IDLE:
  - Only req0 high -> GRANT0.
  - Only req1 high -> GRANT1.
  - Both high -> grant the side ≠ last.
  - Neither high -> stay in IDLE.
- GRANTx, beat definition: a beat occurs in a cycle where gntx=1 and reqx=1. On a beat, dout <= dinx, dout_vld <= 1, cnt++. Otherwise dout_vld <= 0 and dout holds its value.
- GRANTx, release condition: reqx=0 (no beat that cycle), or the beat that makes cnt reach MAX_BURST. On release:
  - last <= x and cnt <= 0.
  - Next state is GRANT(other) if the other req is high.
  - Else GRANTx if reqx is still high (burst-limit case with no competitor; cnt restarts).
  - Else IDLE.
- sel tracks the granted side: 0 in GRANT0, 1 in GRANT1. It holds its last value in IDLE.
- gnt0 and gnt1 are never high together. busy = gnt0 | gnt1.
- Requester behaviour: a requester may deassert req at any time. A deassertion ends its grant after that cycle and loses no data.

## Timing
- Request latency: req rises in IDLE at edge N -> gnt visible after edge N+1.
- Data latency: a beat in cycle K -> dout/dout_vld valid in cycle K+1.
- Sustained throughput: one beat per cycle while the granted requester holds req.
- Switch on burst limit with the other side waiting: zero dead cycles. The MAX_BURST-th beat of side x in cycle K is followed by gnt(other) in cycle K+1.
- Switch on req drop: one dead cycle. In that cycle reqx=0 and dout_vld=0, and the new grant is visible the next cycle.
- Simultaneous first requests from IDLE: the side ≠ last wins. The loser waits at most MAX_BURST beats plus one cycle.
- MAX_BURST=1: grants alternate every cycle while both sides request.
- Reset mid-burst: all outputs clear to their reset values immediately and asynchronously, without waiting for clk. The in-flight beat is discarded. After rst falls, the next edge behaves as from IDLE with last=1.
- sel changes only on clk edges and stays glitch-free relative to gnt.

## Test plan
- Reset: assert rst mid-burst in GRANT1 with cnt=2 -> gnt1, sel, dout_vld, busy drop to 0 without waiting for clk. After release, simultaneous req0=req1=1 -> gnt0 first.
- Single requester: req0=1 for 6 cycles, din0=0x11..0x16, MAX_BURST=4 -> gnt0 held and re-granted. dout shows 0x11..0x16 on consecutive cycles, one cycle late. dout_vld is never low between beats.
- Contention: req0=req1=1 continuously, MAX_BURST=4 -> exactly 4 beats from input 0, then 4 from input 1, alternating. sel toggles with zero dead cycles at each switch.
- Early drop: in GRANT0, req0 falls after 2 beats while req1=1 -> 1 cycle with dout_vld=0, then gnt1=1 and sel=1. cnt restarts, so input 1 gets a full 4 beats.
- MAX_BURST=1 with both requesting -> gnt0/gnt1 alternate every cycle. dout alternates din0/din1.
- Idle return: both reqs drop -> state IDLE, busy=0, sel holds its last value. A later lone req1 -> gnt1 one cycle after the request.
